// File: rtl/nfc_atom_data_read_pkg.sv
// Shared definitions for the NV-DDR data-out read atom: FSM encoding and
// the pin patterns driven toward the PHY while the atom owns the bus.
package nfc_atom_data_read_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRE    = 3'd1,
    ST_TOGGLE = 3'd2,
    ST_POST   = 3'd3,
    ST_DRAIN  = 3'd4
  } state_t;

  // RE is a 4-phase pattern per system clock; 0011 parks it high, 0101 is one toggle.
  localparam logic [3:0]  RE_IDLE    = 4'b0011;
  localparam logic [3:0]  RE_TOGGLE  = 4'b0101;
  localparam logic [3:0]  WE_IDLE    = 4'b0000;
  localparam logic [3:0]  LATCH_IDLE = 4'h0;
  localparam logic [7:0]  DQS_IDLE   = 8'h00;
  localparam logic [31:0] DQ_IDLE    = 32'h0;

endpackage

// File: rtl/nfc_atom_data_read_fifo.sv
// First-word-fall-through read buffer: o_data shows the oldest entry whenever
// o_empty is low. Push on a full buffer or pop on an empty one is dropped.
module nfc_read_fifo #(
  parameter int Depth = 8,
  parameter int Width = 32,
  localparam int Aw = $clog2(Depth)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [Width-1:0] i_data,
  input  logic             i_pop,
  output logic [Width-1:0] o_data,
  output logic [Aw:0]      o_count,
  output logic             o_empty,
  output logic             o_full
);

  logic [Width-1:0] r_mem [Depth];
  logic [Aw-1:0]    r_wr_ptr;
  logic [Aw-1:0]    r_rd_ptr;
  logic [Aw:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (Aw+1)'(Depth));
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/nfc_atom_data_read.sv
// Data-out read atom: toggles RE toward the PHY only when a buffer slot is
// guaranteed, buffers captured words and streams them out with valid/ready.
module nfc_atom_data_read
  import nfc_atom_data_read_pkg::*;
#(
  parameter int NumberOfWays    = 4,
  parameter int FifoDepth       = 8,
  parameter int PreambleCycles  = 2,
  parameter int PostambleCycles = 2
) (
  input  logic                      iSystemClock,
  input  logic                      iReset,
  input  logic                      iStart,
  input  logic [NumberOfWays-1:0]   iTargetWay,
  input  logic [15:0]               iNumOfData,
  output logic                      oReady,
  output logic                      oLastStep,
  output logic                      oDQSOutEnable,
  output logic                      oDQOutEnable,
  output logic [7:0]                oDQStrobe,
  output logic [31:0]               oDQ,
  output logic [2*NumberOfWays-1:0] oChipEnable,
  output logic [3:0]                oReadEnable,
  output logic [3:0]                oWriteEnable,
  output logic [3:0]                oAddressLatchEnable,
  output logic [3:0]                oCommandLatchEnable,
  input  logic [31:0]               iPhyReadData,
  input  logic                      iPhyReadValid,
  output logic [31:0]               oReadData,
  output logic                      oReadDataValid,
  output logic                      oReadDataLast,
  input  logic                      iReadDataReady,
  output logic [2:0]                oDebugState
);

  localparam int FifoAw = $clog2(FifoDepth);
  localparam logic [7:0] PreLast  = 8'(PreambleCycles - 1);
  localparam logic [7:0] PostLast = 8'(PostambleCycles - 1);

  // Valid/ready: a word moves to the data mover in every cycle where
  // oReadDataValid and iReadDataReady are both high; data is held otherwise.
  state_t                    r_state;
  logic [NumberOfWays-1:0]   r_way;
  logic [15:0]               r_count;
  logic [15:0]               r_issued;
  logic [15:0]               r_received;
  logic [15:0]               r_popped;
  logic [7:0]                r_phase;
  logic                      r_ready;
  logic                      r_last_step;
  logic                      r_dqs_oe;
  logic                      r_dq_oe;
  logic [2*NumberOfWays-1:0] r_ce;
  logic [3:0]                r_re;

  logic [31:0]       w_fifo_data;
  logic [FifoAw:0]   w_fifo_count;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic              w_push;
  logic              w_pop;
  logic              w_final_pop;
  logic [15:0]       w_outstanding;
  logic [17:0]       w_committed;
  logic              w_has_credit;
  logic              w_more_to_issue;

  assign w_push = iPhyReadValid && (r_state != ST_IDLE) && (r_received != r_count) && !w_fifo_full;
  assign w_pop  = !w_fifo_empty && iReadDataReady;
  assign w_final_pop = w_pop && (r_popped == r_count - 16'd1);

  // Slots already spoken for: words sitting in the buffer plus toggles
  // (including the one on the pins now) whose data has not come back yet.
  assign w_outstanding   = r_issued - r_received;
  assign w_committed     = {2'b00, w_outstanding} + 18'(w_fifo_count);
  assign w_has_credit    = w_committed < 18'(FifoDepth);
  assign w_more_to_issue = r_issued != r_count;

  nfc_read_fifo #(
    .Depth (FifoDepth),
    .Width (32)
  ) u_fifo (
    .i_clk   (iSystemClock),
    .i_reset (iReset),
    .i_push  (w_push),
    .i_data  (iPhyReadData),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  always_ff @(posedge iSystemClock) begin
    if (iReset) begin
      r_state     <= ST_IDLE;
      r_way       <= '0;
      r_count     <= '0;
      r_issued    <= '0;
      r_received  <= '0;
      r_popped    <= '0;
      r_phase     <= '0;
      r_ready     <= 1'b1;
      r_last_step <= 1'b0;
      r_dqs_oe    <= 1'b1;
      r_dq_oe     <= 1'b1;
      r_ce        <= '0;
      r_re        <= RE_IDLE;
    end else begin
      r_last_step <= w_final_pop;
      if (w_push) r_received <= r_received + 16'd1;
      if (w_pop)  r_popped   <= r_popped + 16'd1;
      case (r_state)
        ST_IDLE: begin
          if (iStart) begin
            r_way      <= iTargetWay;
            r_count    <= iNumOfData;
            r_issued   <= '0;
            r_received <= '0;
            r_popped   <= '0;
            r_phase    <= '0;
            if (iNumOfData == 16'd0) begin
              r_last_step <= 1'b1;
            end else begin
              r_state  <= ST_PRE;
              r_ready  <= 1'b0;
              r_ce     <= {iTargetWay, iTargetWay};
              r_dqs_oe <= 1'b0;
              r_dq_oe  <= 1'b0;
            end
          end
        end
        ST_PRE: begin
          if (r_phase == PreLast) begin
            r_state <= ST_TOGGLE;
            r_phase <= '0;
            if (w_has_credit && w_more_to_issue) begin
              r_re     <= RE_TOGGLE;
              r_issued <= r_issued + 16'd1;
            end
          end else begin
            r_phase <= r_phase + 8'd1;
          end
        end
        ST_TOGGLE: begin
          if (!w_more_to_issue) begin
            r_state <= ST_POST;
            r_re    <= RE_IDLE;
            r_phase <= '0;
          end else if (w_has_credit) begin
            r_re     <= RE_TOGGLE;
            r_issued <= r_issued + 16'd1;
          end else begin
            r_re <= RE_IDLE;
          end
        end
        ST_POST: begin
          if (r_phase == PostLast) begin
            r_state  <= ST_DRAIN;
            r_ce     <= '0;
            r_dqs_oe <= 1'b1;
            r_dq_oe  <= 1'b1;
          end else begin
            r_phase <= r_phase + 8'd1;
          end
        end
        ST_DRAIN: begin
          // Leave together with the final handshake so oReady and oLastStep rise on the same cycle.
          if ((r_received == r_count) && (w_fifo_empty || w_final_pop)) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign oReady              = r_ready;
  assign oLastStep           = r_last_step;
  assign oDQSOutEnable       = r_dqs_oe;
  assign oDQOutEnable        = r_dq_oe;
  assign oDQStrobe           = DQS_IDLE;
  assign oDQ                 = DQ_IDLE;
  assign oChipEnable         = r_ce;
  assign oReadEnable         = r_re;
  assign oWriteEnable        = WE_IDLE;
  assign oAddressLatchEnable = LATCH_IDLE;
  assign oCommandLatchEnable = LATCH_IDLE;
  assign oReadData           = w_fifo_data;
  assign oReadDataValid      = !w_fifo_empty;
  assign oReadDataLast       = !w_fifo_empty && (r_popped == r_count - 16'd1);
  assign oDebugState         = r_state;

  // r_way is kept for the transfer's lifetime; CE is built from it at start.
  logic w_unused_way;
  assign w_unused_way = ^r_way;

endmodule

// File: tb/tb_nfc_atom_data_read.sv
// Self-checking bench for the read atom: table of transfers against a PHY
// echo model and word scoreboard, plus hand-written multi-cycle corner cases.
module tb_nfc_atom_data_read;

  localparam int FIFO_DEPTH = 8;
  localparam logic [3:0] RE_PARK = 4'b0011;
  localparam logic [3:0] RE_TOG  = 4'b0101;

  logic        clk;
  logic        iReset;
  logic        iStart;
  logic [3:0]  iTargetWay;
  logic [15:0] iNumOfData;
  logic        oReady, oLastStep, oDQSOutEnable, oDQOutEnable;
  logic [7:0]  oDQStrobe;
  logic [31:0] oDQ;
  logic [7:0]  oChipEnable;
  logic [3:0]  oReadEnable, oWriteEnable, oAddressLatchEnable, oCommandLatchEnable;
  logic [31:0] iPhyReadData;
  logic        iPhyReadValid;
  logic [31:0] oReadData;
  logic        oReadDataValid, oReadDataLast;
  logic        iReadDataReady;
  logic [2:0]  oDebugState;

  nfc_atom_data_read dut (
    .iSystemClock        (clk),
    .iReset              (iReset),
    .iStart              (iStart),
    .iTargetWay          (iTargetWay),
    .iNumOfData          (iNumOfData),
    .oReady              (oReady),
    .oLastStep           (oLastStep),
    .oDQSOutEnable       (oDQSOutEnable),
    .oDQOutEnable        (oDQOutEnable),
    .oDQStrobe           (oDQStrobe),
    .oDQ                 (oDQ),
    .oChipEnable         (oChipEnable),
    .oReadEnable         (oReadEnable),
    .oWriteEnable        (oWriteEnable),
    .oAddressLatchEnable (oAddressLatchEnable),
    .oCommandLatchEnable (oCommandLatchEnable),
    .iPhyReadData        (iPhyReadData),
    .iPhyReadValid       (iPhyReadValid),
    .oReadData           (oReadData),
    .oReadDataValid      (oReadDataValid),
    .oReadDataLast       (oReadDataLast),
    .iReadDataReady      (iReadDataReady),
    .oDebugState         (oDebugState)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];
  int phy_due_q[$];
  int last_due = 0;
  int lat_min = 3;
  int lat_max = 3;
  int ready_mode = 0;
  bit phy_record = 1'b1;
  int toggle_cnt = 0;
  int pop_cnt = 0;
  int last_step_cnt = 0;
  int first_toggle_cyc = -1;
  int max_inflight = 0;
  int cur_count = 0;
  logic [3:0] cur_way = '0;
  int start_cyc = 0;

  typedef struct {
    int         count;
    logic [3:0] way;
    int         rdy_mode;
    int         lmin;
    int         lmax;
    int         exp_toggles;
    int         exp_first_lat;
  } vec_t;

  // ---------------- clock / reset / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // ---------------- PHY echo model: returns one fresh word per toggle after its latency
  initial begin : phy_model
    logic [31:0] w;
    iPhyReadValid = 1'b0;
    iPhyReadData  = '0;
    forever begin
      @(posedge clk); #1;
      if (phy_due_q.size() != 0 && phy_due_q[0] <= cyc) begin
        void'(phy_due_q.pop_front());
        w = $urandom;
        iPhyReadValid = 1'b1;
        iPhyReadData  = w;
        if (phy_record) exp_q.push_back(w);
      end else begin
        iPhyReadValid = 1'b0;
      end
    end
  end

  // ---------------- data mover ready driver
  initial begin
    iReadDataReady = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       iReadDataReady = 1'b1;
        1:       iReadDataReady = 1'($urandom_range(0, 1));
        default: iReadDataReady = 1'b0;
      endcase
    end
  end

  // ---------------- monitor + scoreboard
  initial begin : monitor
    logic [31:0] e;
    int lat, due, inflight;
    forever begin
      @(negedge clk);
      if (oReadEnable == RE_TOG) begin
        toggle_cnt++;
        if (first_toggle_cyc < 0) first_toggle_cyc = cyc;
        lat = $urandom_range(lat_max, lat_min);
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        phy_due_q.push_back(due);
        checks++;
        if (oChipEnable !== {cur_way, cur_way}) begin
          failures++;
          $display("FAIL ce_on_toggle actual=%0h expected=%0h", oChipEnable, {cur_way, cur_way});
        end
      end
      inflight = toggle_cnt - pop_cnt;
      if (inflight > max_inflight) max_inflight = inflight;
      if (oReadDataValid && iReadDataReady) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL word_unexpected actual=%0h expected=none", oReadData);
        end else begin
          e = exp_q.pop_front();
          if (oReadData !== e) begin
            failures++;
            $display("FAIL word_data idx=%0d actual=%0h expected=%0h", pop_cnt, oReadData, e);
          end
        end
        checks++;
        if (oReadDataLast !== (pop_cnt == cur_count - 1)) begin
          failures++;
          $display("FAIL word_last idx=%0d actual=%0b expected=%0b", pop_cnt, oReadDataLast, (pop_cnt == cur_count - 1));
        end
        pop_cnt++;
      end
      if (oLastStep) last_step_cnt++;
    end
  end

  // ---------------- driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic begin_xfer(input int count, input logic [3:0] way);
    toggle_cnt = 0;
    pop_cnt = 0;
    last_step_cnt = 0;
    first_toggle_cyc = -1;
    max_inflight = 0;
    cur_count = count;
    cur_way = way;
    start_cyc = cyc;
    iStart = 1'b1;
    iNumOfData = 16'(count);
    iTargetWay = way;
    tick(1);
    iStart = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    n = 0;
    while (last_step_cnt == 0 && n < budget) begin
      tick(1);
      n++;
    end
    check({name, "_done"}, 64'(last_step_cnt != 0), 64'd1);
    tick(3);
  endtask

  task automatic check_idle_values(input string name);
    check({name, "_ready"}, 64'(oReady), 64'd1);
    check({name, "_laststep"}, 64'(oLastStep), 64'd0);
    check({name, "_dqs_oe"}, 64'(oDQSOutEnable), 64'd1);
    check({name, "_dq_oe"}, 64'(oDQOutEnable), 64'd1);
    check({name, "_ce"}, 64'(oChipEnable), 64'd0);
    check({name, "_re"}, 64'(oReadEnable), 64'(RE_PARK));
    check({name, "_valid"}, 64'(oReadDataValid), 64'd0);
    check({name, "_last"}, 64'(oReadDataLast), 64'd0);
  endtask

  // ---------------- main sequence
  vec_t vecs[6];

  initial begin
    vecs[0] = '{count: 4,  way: 4'b0001, rdy_mode: 0, lmin: 3, lmax: 3, exp_toggles: 4,  exp_first_lat: 3};
    vecs[1] = '{count: 1,  way: 4'b0010, rdy_mode: 0, lmin: 1, lmax: 1, exp_toggles: 1,  exp_first_lat: 3};
    vecs[2] = '{count: 8,  way: 4'b0100, rdy_mode: 1, lmin: 2, lmax: 5, exp_toggles: 8,  exp_first_lat: 3};
    vecs[3] = '{count: 13, way: 4'b1000, rdy_mode: 1, lmin: 1, lmax: 6, exp_toggles: 13, exp_first_lat: 3};
    vecs[4] = '{count: 37, way: 4'b0011, rdy_mode: 1, lmin: 1, lmax: 6, exp_toggles: 37, exp_first_lat: 3};
    vecs[5] = '{count: 64, way: 4'b0101, rdy_mode: 0, lmin: 6, lmax: 6, exp_toggles: 64, exp_first_lat: 3};

    iReset = 1'b1;
    iStart = 1'b0;
    iTargetWay = '0;
    iNumOfData = '0;
    tick(3);
    iReset = 1'b0;
    tick(1);
    check_idle_values("reset");
    check("reset_dq", 64'(oDQ), 64'd0);
    check("reset_dqs", 64'(oDQStrobe), 64'd0);
    check("reset_we", 64'(oWriteEnable), 64'd0);
    check("reset_ale_cle", 64'({oAddressLatchEnable, oCommandLatchEnable}), 64'd0);

    foreach (vecs[i]) begin
      ready_mode = vecs[i].rdy_mode;
      lat_min = vecs[i].lmin;
      lat_max = vecs[i].lmax;
      begin_xfer(vecs[i].count, vecs[i].way);
      wait_done(3000, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_toggles", i), 64'(toggle_cnt), 64'(vecs[i].exp_toggles));
      check($sformatf("vec%0d_words", i), 64'(pop_cnt), 64'(vecs[i].count));
      check($sformatf("vec%0d_laststeps", i), 64'(last_step_cnt), 64'd1);
      check($sformatf("vec%0d_first_re", i), 64'(first_toggle_cyc - start_cyc), 64'(vecs[i].exp_first_lat));
      check($sformatf("vec%0d_leftover", i), 64'(exp_q.size()), 64'd0);
      check($sformatf("vec%0d_credit", i), 64'(max_inflight <= FIFO_DEPTH), 64'd1);
      check($sformatf("vec%0d_ready", i), 64'(oReady), 64'd1);
    end

    // zero-length transfer: no bus activity, LastStep the cycle after start
    ready_mode = 0;
    lat_min = 3;
    lat_max = 3;
    begin_xfer(0, 4'b1010);
    check("zero_laststep_hi", 64'(oLastStep), 64'd1);
    check("zero_ce", 64'(oChipEnable), 64'd0);
    check("zero_re", 64'(oReadEnable), 64'(RE_PARK));
    tick(1);
    check("zero_laststep_lo", 64'(oLastStep), 64'd0);
    tick(3);
    check("zero_toggles", 64'(toggle_cnt), 64'd0);
    check("zero_laststep_cnt", 64'(last_step_cnt), 64'd1);
    check("zero_ready", 64'(oReady), 64'd1);

    // back-pressure: buffer credit stops RE after FifoDepth toggles
    ready_mode = 2;
    begin_xfer(20, 4'b0110);
    tick(40);
    check("bp_toggles_paused", 64'(toggle_cnt), 64'(FIFO_DEPTH));
    check("bp_re_parked", 64'(oReadEnable), 64'(RE_PARK));
    check("bp_valid_held", 64'(oReadDataValid), 64'd1);
    ready_mode = 0;
    wait_done(1000, "bp");
    check("bp_toggles", 64'(toggle_cnt), 64'd20);
    check("bp_words", 64'(pop_cnt), 64'd20);
    check("bp_leftover", 64'(exp_q.size()), 64'd0);
    check("bp_credit", 64'(max_inflight <= FIFO_DEPTH), 64'd1);

    // reset in the middle of TOGGLE
    ready_mode = 2;
    begin_xfer(30, 4'b1001);
    begin
      int n;
      n = 0;
      while (toggle_cnt < 5 && n < 200) begin
        tick(1);
        n++;
      end
    end
    check("rst_reached_toggle", 64'(toggle_cnt >= 5), 64'd1);
    phy_record = 1'b0;
    iReset = 1'b1;
    tick(1);
    iReset = 1'b0;
    exp_q.delete();
    check_idle_values("midrst");
    tick(12);
    check("midrst_valid_later", 64'(oReadDataValid), 64'd0);
    check("midrst_ready_later", 64'(oReady), 64'd1);
    check("midrst_no_laststep", 64'(last_step_cnt), 64'd0);
    phy_record = 1'b1;
    exp_q.delete();

    // a second start during TOGGLE must be ignored
    ready_mode = 0;
    begin_xfer(6, 4'b0011);
    tick(4);
    iStart = 1'b1;
    iNumOfData = 16'd2;
    iTargetWay = 4'b1100;
    tick(1);
    iStart = 1'b0;
    wait_done(500, "restart");
    tick(5);
    check("restart_toggles", 64'(toggle_cnt), 64'd6);
    check("restart_words", 64'(pop_cnt), 64'd6);
    check("restart_laststeps", 64'(last_step_cnt), 64'd1);
    check("restart_leftover", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
